comparator: RTL and testbench

Operand comparator for the pipelined MIPS core's decode stage, used for early branch resolution. It takes two packed BIT_WIDTH operands and drives a zero-latency `equal` flag. It also produces a registered, valid-qualified set of branch-condition flags one cycle later. Supported conditions: BEQ, BNE, BLTZ, BLEZ, BGTZ, BGEZ and SLT/SLTU-style compares.

---
 rtl/comparator_pkg.sv | 20 ++
 rtl/comparator_if.sv | 32 +++
 rtl/comparator_core.sv | 46 ++++
 rtl/comparator.sv | 55 +++++
 tb/tb_comparator.sv | 137 +++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the decode-stage branch operand comparator.
// Magnitude flags are built only when COMPARATOR_MAGNITUDE_EN is defined.
package comparator_pkg;

    localparam int DEFAULT_BIT_WIDTH = 32;

    typedef struct packed {
        logic eq;
        logic ne;
        logic lts;
        logic ltu;
        logic ltz;
        logic lez;
        logic gtz;
        logic gez;
    } cmp_flags_t;

    localparam cmp_flags_t CMP_FLAGS_RESET = '0;

endpackage

// File: rtl/comparator_if.sv
// Operand/flag bundle between the decode stage and the comparator.
// The slave modport is the comparator side, the master is the decode stage.
interface comparator_if
    import comparator_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);
    logic [2*BIT_WIDTH-1:0] dataIn;
    logic                   validIn;
    logic                   equal;
    logic                   validOut;
    logic                   eqOut;
    logic                   neOut;
    logic                   ltsOut;
    logic                   ltuOut;
    logic                   ltzOut;
    logic                   lezOut;
    logic                   gtzOut;
    logic                   gezOut;

    modport master (
        output dataIn, validIn,
        input  equal, validOut, eqOut, neOut, ltsOut, ltuOut,
               ltzOut, lezOut, gtzOut, gezOut
    );

    modport slave (
        input  dataIn, validIn,
        output equal, validOut, eqOut, neOut, ltsOut, ltuOut,
               ltzOut, lezOut, gtzOut, gezOut
    );
endinterface

// File: rtl/comparator_core.sv
// Combinational branch-condition flag generator for operands A and B.
// COMPARATOR_MAGNITUDE_EN builds the subtractor; otherwise magnitude flags are 0.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output cmp_flags_t           flags
);

    logic eq;

    assign eq = &(a ~^ b);

`ifdef COMPARATOR_MAGNITUDE_EN
    logic [BIT_WIDTH:0] diff;
    logic               ovf;
    logic               a_zero;

    assign diff   = {1'b0, a} - {1'b0, b};
    // Overflow only when the operand signs differ and the result sign departs from A.
    assign ovf    = (a[BIT_WIDTH-1] ^ b[BIT_WIDTH-1]) & (a[BIT_WIDTH-1] ^ diff[BIT_WIDTH-1]);
    assign a_zero = ~|a;

    always_comb begin
        flags     = CMP_FLAGS_RESET;
        flags.eq  = eq;
        flags.ne  = ~eq;
        flags.ltu = diff[BIT_WIDTH];
        flags.lts = diff[BIT_WIDTH-1] ^ ovf;
        flags.ltz = a[BIT_WIDTH-1];
        flags.lez = a[BIT_WIDTH-1] | a_zero;
        flags.gtz = ~(a[BIT_WIDTH-1] | a_zero);
        flags.gez = ~a[BIT_WIDTH-1];
    end
`else
    always_comb begin
        flags    = CMP_FLAGS_RESET;
        flags.eq = eq;
        flags.ne = ~eq;
    end
`endif

endmodule

// File: rtl/comparator.sv
// Early branch-resolution comparator: zero-latency equal plus registered flags.
// Magnitude flags depend on COMPARATOR_MAGNITUDE_EN (see comparator_core).
module comparator
    import comparator_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    comparator_if.slave  bus
);

    logic [BIT_WIDTH-1:0] op_a;
    logic [BIT_WIDTH-1:0] op_b;
    cmp_flags_t           flags_next;
    cmp_flags_t           flags_q;
    logic                 valid_q;

    assign op_a = bus.dataIn[2*BIT_WIDTH-1:BIT_WIDTH];
    assign op_b = bus.dataIn[BIT_WIDTH-1:0];

    comparator_core #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_core (
        .a     (op_a),
        .b     (op_b),
        .flags (flags_next)
    );

    assign bus.equal = flags_next.eq;

    // Flags hold across idle cycles; validOut alone marks them fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= CMP_FLAGS_RESET;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.validIn;
            if (bus.validIn) begin
                flags_q <= flags_next;
            end
        end
    end

    assign bus.validOut = valid_q;
    assign bus.eqOut    = flags_q.eq;
    assign bus.neOut    = flags_q.ne;
    assign bus.ltsOut   = flags_q.lts;
    assign bus.ltuOut   = flags_q.ltu;
    assign bus.ltzOut   = flags_q.ltz;
    assign bus.lezOut   = flags_q.lez;
    assign bus.gtzOut   = flags_q.gtz;
    assign bus.gezOut   = flags_q.gez;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: stimulus pushes expected registered outputs,
// a monitor pops one per clock and compares. Expectations track COMPARATOR_MAGNITUDE_EN.
module tb_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    // Expected word: {valid, eq, ne, lts, ltu, ltz, lez, gtz, gez}
    logic [8:0] exp_q[$];

`ifdef COMPARATOR_MAGNITUDE_EN
    localparam logic [8:0] MASK = 9'b111_111111;
`else
    localparam logic [8:0] MASK = 9'b111_000000;
`endif

    comparator_if #(.BIT_WIDTH(32)) bus ();

    comparator #(.BIT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] actual();
        return {bus.validOut, bus.eqOut, bus.neOut, bus.ltsOut, bus.ltuOut,
                bus.ltzOut, bus.lezOut, bus.gtzOut, bus.gezOut};
    endfunction

    initial begin : monitor
        logic [8:0] exp;
        logic [8:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = actual();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL regs: got %b required %b (valid,eq,ne,lts,ltu,ltz,lez,gtz,gez)",
                             got, exp);
                end
            end
        end
    end

    task automatic check_equal(input string name, input logic exp_eq);
        vectors++;
        if (bus.equal !== exp_eq) begin
            miscompares++;
            $display("FAIL %s: equal got %b required %b dataIn=%h", name, bus.equal, exp_eq, bus.dataIn);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] d,
                        input logic exp_eq, input logic [8:0] exp);
        @(negedge clk);
        rst         = r;
        bus.validIn = v;
        bus.dataIn  = d;
        #1;
        check_equal("equal_clocked", exp_eq);
        exp_q.push_back(exp & MASK);
    endtask

    typedef struct {
        logic [63:0] d;
        logic        e;
    } comb_vec_t;

    comb_vec_t comb_vecs[4] = '{
        '{64'h00001111_11110000, 1'b0},
        '{64'h11111111_11111111, 1'b1},
        '{64'h00000000_00000000, 1'b1},
        '{64'h10101010_01010101, 1'b0}
    };

    initial begin : stimulus
        bus.validIn = 1'b0;
        bus.dataIn  = '0;

        foreach (comb_vecs[i]) begin
            bus.dataIn = comb_vecs[i].d;
            #25;
            check_equal("equal_comb", comb_vecs[i].e);
            #25;
        end

        // Reset held two cycles with validIn high
        step(1, 1, 64'hFFFFFFFF_00000001, 0, 9'b0_00_000000);
        step(1, 1, 64'h00000005_00000005, 1, 9'b0_00_000000);

        // Signed vs unsigned
        step(0, 1, 64'hFFFFFFFF_00000001, 0, 9'b1_01_101100);
        // Zero, then positive max vs most negative
        step(0, 1, 64'h00000000_00000000, 1, 9'b1_10_000101);
        step(0, 1, 64'h7FFFFFFF_80000000, 0, 9'b1_01_010011);

        // Idle cycles: flags hold, validOut drops
        step(0, 0, 64'h00000000_00000000, 1, 9'b0_01_010011);
        step(0, 0, 64'h00000001_00000002, 0, 9'b0_01_010011);
        step(0, 0, 64'h80000000_00000000, 0, 9'b0_01_010011);

        // More patterns back to back
        step(0, 1, 64'h00000005_00000003, 0, 9'b1_01_000011);
        step(0, 1, 64'h80000000_7FFFFFFF, 0, 9'b1_01_101100);
        step(0, 1, 64'h00000003_00000005, 0, 9'b1_01_110011);

        // rst wins over validIn
        step(1, 1, 64'h00000003_00000003, 1, 9'b0_00_000000);
        step(0, 1, 64'h00000003_00000003, 1, 9'b1_10_000011);
        step(0, 1, 64'hFFFFFFFF_FFFFFFFF, 1, 9'b1_10_001100);
        // Mid-stream reset, then idle stays cleared
        step(1, 0, 64'h00000001_00000000, 0, 9'b0_00_000000);
        step(0, 0, 64'h00000001_00000000, 0, 9'b0_00_000000);

        @(negedge clk);
        bus.validIn = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
